// File: rtl/sii_ncu_arb.sv
// SII->NCU inbound link arbiter and sequencer.
// Two sources share one request/grant/data channel: Mondo interrupts and
// PIO completions. They are served alternately, round-robin. Each packet
// is a 16-bit header plus a 128-bit payload. It is sent as one header beat
// and then four 32-bit payload beats, most significant beat first. Each
// 16-bit half of the bus carries its own even parity bit.
module sii_ncu_arb #(
  parameter int unsigned GNT_TIMEOUT = 255
) (
  input  logic         iol2clk,
  input  logic         rst_l,
  input  logic         mondo_vld,
  input  logic [15:0]  mondo_hdr,
  input  logic [127:0] mondo_data,
  output logic         mondo_ack,
  input  logic         pio_vld,
  input  logic [15:0]  pio_hdr,
  input  logic [127:0] pio_data,
  output logic         pio_ack,
  input  logic         ncu_sii_gnt,
  output logic         sii_ncu_req,
  output logic [31:0]  sii_ncu_data,
  output logic [1:0]   sii_ncu_dparity,
  output logic         busy,
  output logic         proto_err,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_HDR, S_PL0, S_PL1, S_PL2, S_PL3
  } state_e;

  localparam logic        SRC_MONDO   = 1'b0;
  localparam logic        SRC_PIO     = 1'b1;
  localparam logic [15:0] TIMEOUT_CNT = 16'(GNT_TIMEOUT);

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [143:0]   buf_q, buf_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           req_q, req_d;
  logic [31:0]    data_q, data_d;
  logic [1:0]     par_q, par_d;
  logic           mack_q, mack_d;
  logic           pack_q, pack_d;
  logic           busy_q, busy_d;
  logic           perr_q, perr_d;
  logic           terr_q, terr_d;
  logic           pick_pio;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Even parity of each 16-bit half of a bus word.
  function automatic logic [1:0] half_parity(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  // On a tie, the source that was not served last wins.
  assign pick_pio = pio_vld && (!mondo_vld || (last_q == SRC_MONDO));

  // State register.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one header beat and four payload beats per grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mondo_vld || pio_vld) state_d = S_REQ;
      S_REQ:   if (ncu_sii_gnt)          state_d = S_HDR;
      S_HDR:   state_d = S_PL0;
      S_PL0:   state_d = S_PL1;
      S_PL1:   state_d = S_PL2;
      S_PL2:   state_d = S_PL3;
      S_PL3:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. Every port is a register, so each
  // value is computed here for the cycle after the current one.
  always_comb begin
    buf_d  = buf_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    req_d  = 1'b0;
    data_d = 32'h0;
    mack_d = 1'b0;
    pack_d = 1'b0;
    perr_d = perr_q | (ncu_sii_gnt && (state_q != S_REQ));
    terr_d = terr_q;
    case (state_q)
      S_IDLE: begin
        if (mondo_vld || pio_vld) begin
          buf_d  = pick_pio ? {pio_hdr, pio_data} : {mondo_hdr, mondo_data};
          last_d = pick_pio ? SRC_PIO : SRC_MONDO;
          pack_d = pick_pio;
          mack_d = !pick_pio;
          req_d  = 1'b1;
          cnt_d  = 16'h0;
        end
      end
      S_REQ: begin
        if (ncu_sii_gnt) begin
          data_d = {16'h0, buf_q[143:128]};
        end else begin
          // The request stays up after a timeout. The error flag only
          // records that the NCU was too slow.
          req_d = 1'b1;
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == TIMEOUT_CNT) terr_d = 1'b1;
        end
      end
      S_HDR:   data_d = buf_q[127:96];
      S_PL0:   data_d = buf_q[95:64];
      S_PL1:   data_d = buf_q[63:32];
      S_PL2:   data_d = buf_q[31:0];
      default: data_d = 32'h0;
    endcase
    par_d  = half_parity(data_d);
    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers. All of them clear at once when reset is asserted.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      last_q <= SRC_MONDO;
      cnt_q  <= 16'h0;
      req_q  <= 1'b0;
      data_q <= 32'h0;
      par_q  <= 2'b00;
      mack_q <= 1'b0;
      pack_q <= 1'b0;
      busy_q <= 1'b0;
      perr_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      req_q  <= req_d;
      data_q <= data_d;
      par_q  <= par_d;
      mack_q <= mack_d;
      pack_q <= pack_d;
      busy_q <= busy_d;
      perr_q <= perr_d;
      terr_q <= terr_d;
    end
  end

  // Packet buffer. It is only read after it has been loaded in IDLE, so it has no reset.
  always_ff @(posedge iol2clk) begin
    buf_q <= buf_d;
  end

  assign sii_ncu_req     = req_q;
  assign sii_ncu_data    = data_q;
  assign sii_ncu_dparity = par_q;
  assign mondo_ack       = mack_q;
  assign pio_ack         = pack_q;
  assign busy            = busy_q;
  assign proto_err       = perr_q;
  assign timeout_err     = terr_q;

endmodule
